// File: rtl/runner_motion_if.sv
// Strobe/button bundle from the game-control FSM and the runner position/pose
// outputs that the FSM, collision detector and man drawer read back.
interface runner_motion_if;
  logic       update;
  logic       ld_x;
  logic       ld_y;
  logic       ld_man_style;
  logic       btn_jump;
  logic       btn_crouch;
  logic       btn_lane_up;
  logic       btn_lane_down;
  logic [7:0] x_w;
  logic [6:0] y_w;
  logic       crouch;
  logic [1:0] man_style;
  logic [1:0] lane;
  logic       airborne;

  modport master (
    output update, ld_x, ld_y, ld_man_style,
    output btn_jump, btn_crouch, btn_lane_up, btn_lane_down,
    input  x_w, y_w, crouch, man_style, lane, airborne
  );

  modport slave (
    input  update, ld_x, ld_y, ld_man_style,
    input  btn_jump, btn_crouch, btn_lane_up, btn_lane_down,
    output x_w, y_w, crouch, man_style, lane, airborne
  );
endinterface

// File: rtl/runner_motion.sv
// Runner position/pose datapath: working x/y/lane plus a jump/crouch state
// machine that advances one step per update pulse; ld_* strobes publish it.
//
// state     | meaning
// RUN       | on the ground in a lane, run frames alternate
// JUMP_UP   | rising by JUMP_STEP per update
// JUMP_DOWN | falling by JUMP_STEP per update, lands on lane base
// CROUCH    | crouched while btn_crouch is held at update
module runner_motion #(
  parameter int X_START   = 20,
  parameter int X_MAX     = 40,
  parameter int X_STEP    = 1,
  parameter int LANE0_Y   = 29,
  parameter int LANE1_Y   = 69,
  parameter int LANE2_Y   = 109,
  parameter int JUMP_STEP = 2,
  parameter int JUMP_UPS  = 6
) (
  input logic            clk,
  input logic            reset_n,
  runner_motion_if.slave bus
);
  typedef enum logic [1:0] {RUN, JUMP_UP, JUMP_DOWN, CROUCH} state_t;

  localparam logic [7:0] X_START8  = 8'(X_START);
  localparam logic [8:0] X_MAX9    = 9'(X_MAX);
  localparam logic [8:0] X_STEP9   = 9'(X_STEP);
  localparam logic [6:0] LANE0_Y7  = 7'(LANE0_Y);
  localparam logic [6:0] LANE1_Y7  = 7'(LANE1_Y);
  localparam logic [6:0] LANE2_Y7  = 7'(LANE2_Y);
  localparam logic [6:0] JSTEP7    = 7'(JUMP_STEP);
  localparam logic [3:0] JUMP_UPS4 = 4'(JUMP_UPS);

  state_t     state_q, state_d;
  logic [1:0] lane_q, lane_d;
  logic [7:0] x_q, x_d;
  logic [6:0] y_q, y_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] style_q, style_d;
  logic       crouch_q, crouch_d;
  logic       pj_q, pj_d, pu_q, pu_d, pd_q, pd_d;
  logic       jump_prev_q, up_prev_q, dn_prev_q;
  logic [7:0] x_w_q;
  logic [6:0] y_w_q;
  logic       crouch_w_q;
  logic [1:0] style_w_q;
  logic [8:0] x_sum;
  logic [3:0] cnt_inc;

  function automatic logic [6:0] lane_base(input logic [1:0] l);
    case (l)
      2'd0:    return LANE0_Y7;
      2'd2:    return LANE2_Y7;
      default: return LANE1_Y7;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RUN;
      lane_q      <= 2'd1;
      x_q         <= X_START8;
      y_q         <= LANE1_Y7;
      cnt_q       <= 4'd0;
      style_q     <= 2'd0;
      crouch_q    <= 1'b0;
      pj_q        <= 1'b0;
      pu_q        <= 1'b0;
      pd_q        <= 1'b0;
      jump_prev_q <= 1'b0;
      up_prev_q   <= 1'b0;
      dn_prev_q   <= 1'b0;
      x_w_q       <= X_START8;
      y_w_q       <= LANE1_Y7;
      crouch_w_q  <= 1'b0;
      style_w_q   <= 2'd0;
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      x_q         <= x_d;
      y_q         <= y_d;
      cnt_q       <= cnt_d;
      style_q     <= style_d;
      crouch_q    <= crouch_d;
      pj_q        <= pj_d;
      pu_q        <= pu_d;
      pd_q        <= pd_d;
      jump_prev_q <= bus.btn_jump;
      up_prev_q   <= bus.btn_lane_up;
      dn_prev_q   <= bus.btn_lane_down;
      // Loads see the pre-update working values when they coincide with update.
      if (bus.ld_x) x_w_q <= x_q;
      if (bus.ld_y) y_w_q <= y_q;
      if (bus.ld_man_style) begin
        style_w_q  <= style_q;
        crouch_w_q <= crouch_q;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    lane_d   = lane_q;
    x_d      = x_q;
    y_d      = y_q;
    cnt_d    = cnt_q;
    style_d  = style_q;
    crouch_d = crouch_q;
    cnt_inc  = cnt_q + 4'd1;
    x_sum    = {1'b0, x_q} + X_STEP9;
    // Flags are consumed or dropped at every update; an edge in the update cycle
    // itself stays pending for the following update.
    pj_d = (pj_q & ~bus.update) | (bus.btn_jump & ~jump_prev_q);
    pu_d = (pu_q & ~bus.update) | (bus.btn_lane_up & ~up_prev_q);
    pd_d = (pd_q & ~bus.update) | (bus.btn_lane_down & ~dn_prev_q);

    if (bus.update) begin
      x_d = (x_sum > X_MAX9) ? X_START8 : x_sum[7:0];
      case (state_q)
        RUN: begin
          if (pj_q) begin
            state_d = JUMP_UP;
            cnt_d   = 4'd1;
            y_d     = y_q - JSTEP7;
            style_d = 2'd2;
          end else if (bus.btn_crouch) begin
            state_d  = CROUCH;
            style_d  = 2'd3;
            crouch_d = 1'b1;
          end else if (pu_q && !pd_q && lane_q != 2'd0) begin
            lane_d = lane_q - 2'd1;
            y_d    = lane_base(lane_q - 2'd1);
          end else if (pd_q && !pu_q && lane_q != 2'd2) begin
            lane_d = lane_q + 2'd1;
            y_d    = lane_base(lane_q + 2'd1);
          end else begin
            style_d = {1'b0, ~style_q[0]};
          end
        end
        JUMP_UP: begin
          y_d = y_q - JSTEP7;
          if (cnt_inc == JUMP_UPS4) begin
            state_d = JUMP_DOWN;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        JUMP_DOWN: begin
          cnt_d = cnt_inc;
          if (cnt_inc == JUMP_UPS4) begin
            state_d = RUN;
            cnt_d   = 4'd0;
            y_d     = lane_base(lane_q);
            style_d = 2'd0;
          end else begin
            y_d = y_q + JSTEP7;
          end
        end
        CROUCH: begin
          if (!bus.btn_crouch) begin
            state_d  = RUN;
            crouch_d = 1'b0;
            style_d  = 2'd0;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  assign bus.x_w       = x_w_q;
  assign bus.y_w       = y_w_q;
  assign bus.crouch    = crouch_w_q;
  assign bus.man_style = style_w_q;
  assign bus.lane      = lane_q;
  assign bus.airborne  = (state_q == JUMP_UP) || (state_q == JUMP_DOWN);
endmodule

// File: tb/tb_runner_motion.sv
// Directed plus randomized bench for runner_motion; a behavioural model tracks
// position, lane and a precomputed jump trajectory and is compared after each load.
module tb_runner_motion;
  logic clk;
  logic reset_n;
  runner_motion_if bus();

  runner_motion dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int m_x, m_y, m_lane, m_style;
  bit m_crouch;
  bit pj, pu, pd;
  int traj[$];
  int m_xw, m_yw, m_style_w;
  bit m_crouch_w;

  function automatic int base_of(input int l);
    return 29 + 40 * l;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_x = 20; m_y = 69; m_lane = 1; m_style = 0; m_crouch = 0;
    pj = 0; pu = 0; pd = 0;
    traj.delete();
    m_xw = 20; m_yw = 69; m_style_w = 0; m_crouch_w = 0;
  endtask

  task automatic model_update();
    m_x = (m_x + 1 > 40) ? 20 : m_x + 1;
    if (traj.size() > 0) begin
      m_y = traj.pop_front();
      if (traj.size() == 0) m_style = 0;
    end else if (m_crouch) begin
      if (!bus.btn_crouch) begin
        m_crouch = 0;
        m_style  = 0;
      end
    end else if (pj) begin
      for (int k = 1; k <= 6; k++) traj.push_back(base_of(m_lane) - 2 * k);
      for (int k = 5; k >= 0; k--) traj.push_back(base_of(m_lane) - 2 * k);
      m_y = traj.pop_front();
      m_style = 2;
    end else if (bus.btn_crouch) begin
      m_crouch = 1;
      m_style  = 3;
    end else if (pu && !pd && m_lane > 0) begin
      m_lane--;
      m_y = base_of(m_lane);
    end else if (pd && !pu && m_lane < 2) begin
      m_lane++;
      m_y = base_of(m_lane);
    end else begin
      m_style = m_style ^ 1;
    end
    pj = 0; pu = 0; pd = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input bit j, input bit u, input bit d);
    bus.btn_jump = j; bus.btn_lane_up = u; bus.btn_lane_down = d;
    tick();
    if (j) pj = 1;
    if (u) pu = 1;
    if (d) pd = 1;
    bus.btn_jump = 0; bus.btn_lane_up = 0; bus.btn_lane_down = 0;
    tick();
  endtask

  task automatic do_update();
    bus.update = 1;
    tick();
    bus.update = 0;
    model_update();
  endtask

  task automatic check_all(input string tag);
    check({tag, ".x_w"}, 32'(bus.x_w), 32'(m_xw));
    check({tag, ".y_w"}, 32'(bus.y_w), 32'(m_yw));
    check({tag, ".crouch"}, 32'(bus.crouch), 32'(m_crouch_w));
    check({tag, ".style"}, 32'(bus.man_style), 32'(m_style_w));
    check({tag, ".lane"}, 32'(bus.lane), 32'(m_lane));
    check({tag, ".airborne"}, 32'(bus.airborne), 32'(traj.size() > 0));
  endtask

  task automatic load_all(input string tag);
    bus.ld_x = 1; bus.ld_y = 1; bus.ld_man_style = 1;
    tick();
    bus.ld_x = 0; bus.ld_y = 0; bus.ld_man_style = 0;
    m_xw = m_x; m_yw = m_y; m_style_w = m_style; m_crouch_w = m_crouch;
    check_all(tag);
  endtask

  task automatic step(input string tag);
    do_update();
    load_all(tag);
  endtask

  initial begin
    int r;
    reset_n = 0;
    bus.update = 0; bus.ld_x = 0; bus.ld_y = 0; bus.ld_man_style = 0;
    bus.btn_jump = 0; bus.btn_crouch = 0; bus.btn_lane_up = 0; bus.btn_lane_down = 0;
    model_reset();
    repeat (3) tick();
    check_all("in_reset");
    reset_n = 1;
    tick();
    load_all("after_reset");

    for (int i = 0; i < 21; i++) step("run_wrap");
    check("x_wrapped", 32'(bus.x_w), 32'd20);

    press(1, 0, 0);
    for (int i = 0; i < 12; i++) begin
      if (i == 4) press(0, 1, 0);
      step("jump");
    end
    check("jump_landed_y", 32'(bus.y_w), 32'd69);

    bus.btn_crouch = 1;
    tick();
    for (int i = 0; i < 3; i++) step("crouch_hold");
    check("crouch_flag", 32'(bus.crouch), 32'd1);
    bus.btn_crouch = 0;
    tick();
    step("crouch_release");

    bus.btn_crouch = 1;
    press(1, 0, 0);
    step("jump_beats_crouch");
    check("jump_beats_crouch_style", 32'(bus.man_style), 32'd2);
    bus.btn_crouch = 0;
    for (int i = 0; i < 11; i++) step("jump2");

    press(0, 1, 0);
    step("lane_up");
    check("lane0_y", 32'(bus.y_w), 32'd29);
    press(0, 1, 0);
    step("lane_up_drop");
    press(0, 1, 1);
    step("lane_both");

    // update and loads in the same cycle publish the pre-update values
    bus.update = 1; bus.ld_x = 1;
    tick();
    bus.update = 0; bus.ld_x = 0;
    m_xw = m_x;
    model_update();
    check("coincide_x_w", 32'(bus.x_w), 32'(m_xw));
    bus.ld_y = 1;
    tick();
    bus.ld_y = 0;
    m_yw = m_y;
    check("ld_y_only_x_w", 32'(bus.x_w), 32'(m_xw));
    check("ld_y_only_y_w", 32'(bus.y_w), 32'(m_yw));

    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 5);
      case (r)
        0: press(1, 0, 0);
        1: press(0, 1, 0);
        2: press(0, 0, 1);
        3: press(0, 1, 1);
        4: begin
          bus.btn_crouch = 1'($urandom_range(0, 1));
          tick();
        end
        default: tick();
      endcase
      step("random");
    end
    bus.btn_crouch = 0;
    for (int i = 0; i < 14; i++) step("settle");

    press(1, 0, 0);
    for (int i = 0; i < 3; i++) step("pre_reset_jump");
    #2;
    reset_n = 0;
    #1;
    model_reset();
    check_all("async_reset");
    #5;
    reset_n = 1;
    tick();
    step("post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
